// File: rtl/alu_station.sv
// ALU reservation station: holds DEPTH ops, wakes operands from the CDB, issues oldest-index ready op.
// Latency: 1 cycle from allocation (operands present) or CDB wakeup to registered res_en.
// Backpressure: busy when all entries valid; en_in while busy is dropped; rdy low freezes everything.
// Optional: define ALU_STATION_FLUSH_EN to add a 'flush' input that discards all pending entries.
module alu_station #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
`ifdef ALU_STATION_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              en_in,
  input  logic [3:0]        op_in,
  input  logic [TAG_W-1:0]  tagx_in,
  input  logic [TAG_W-1:0]  tagy_in,
  input  logic [TAG_W-1:0]  tagw_in,
  input  logic [WORD_W-1:0] datax_in,
  input  logic [WORD_W-1:0] datay_in,
  input  logic [4:0]        addrw_in,
  input  logic              cdb_en,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [WORD_W-1:0] cdb_data,
  output logic              busy,
  output logic              res_en,
  output logic [TAG_W-1:0]  res_tag,
  output logic [WORD_W-1:0] res_data,
  output logic [4:0]        res_addr
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
    OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
    OP_OR = 4'd8, OP_AND = 4'd9, OP_PASSY = 4'd10
  } sinst_t;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [3:0]        op_q    [DEPTH];
  logic [3:0]        op_d    [DEPTH];
  logic [TAG_W-1:0]  tagx_q  [DEPTH];
  logic [TAG_W-1:0]  tagx_d  [DEPTH];
  logic [TAG_W-1:0]  tagy_q  [DEPTH];
  logic [TAG_W-1:0]  tagy_d  [DEPTH];
  logic [TAG_W-1:0]  tagw_q  [DEPTH];
  logic [TAG_W-1:0]  tagw_d  [DEPTH];
  logic [WORD_W-1:0] datax_q [DEPTH];
  logic [WORD_W-1:0] datax_d [DEPTH];
  logic [WORD_W-1:0] datay_q [DEPTH];
  logic [WORD_W-1:0] datay_d [DEPTH];
  logic [4:0]        addrw_q [DEPTH];
  logic [4:0]        addrw_d [DEPTH];

  logic              res_en_q, res_en_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic [WORD_W-1:0] res_data_q, res_data_d;
  logic [4:0]        res_addr_q, res_addr_d;

  logic              issue_vld;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  free_idx;
  logic              alloc_vld;
  logic              flush_act;
  logic              cdb_live;

`ifdef ALU_STATION_FLUSH_EN
  assign flush_act = rdy && flush;
`else
  assign flush_act = 1'b0;
`endif

  assign busy      = &valid_q;
  assign alloc_vld = rdy && en_in && !busy;
  assign cdb_live  = cdb_en && (cdb_tag != '0);

  assign res_en   = res_en_q;
  assign res_tag  = res_tag_q;
  assign res_data = res_data_q;
  assign res_addr = res_addr_q;

  // Single-cycle ALU; shift amounts use the low five bits of y.
  function automatic logic [WORD_W-1:0] alu(input logic [3:0] op,
                                            input logic [WORD_W-1:0] x,
                                            input logic [WORD_W-1:0] y);
    case (op)
      OP_ADD:   alu = x + y;
      OP_SUB:   alu = x - y;
      OP_SLL:   alu = x << y[4:0];
      OP_SLT:   alu = WORD_W'($signed(x) < $signed(y));
      OP_SLTU:  alu = WORD_W'(x < y);
      OP_XOR:   alu = x ^ y;
      OP_SRL:   alu = x >> y[4:0];
      OP_SRA:   alu = WORD_W'($signed(x) >>> y[4:0]);
      OP_OR:    alu = x | y;
      OP_AND:   alu = x & y;
      OP_PASSY: alu = y;
      default:  alu = '0;
    endcase
  endfunction

  // Pick the lowest-index ready entry to issue and the lowest-index free slot to fill.
  always_comb begin
    issue_vld = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (tagx_q[i] == '0) && (tagy_q[i] == '0)) begin
        issue_vld = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // Next state: wakeup, issue, allocation with CDB capture, then flush override.
  always_comb begin
    valid_d    = valid_q;
    op_d       = op_q;
    tagx_d     = tagx_q;
    tagy_d     = tagy_q;
    tagw_d     = tagw_q;
    datax_d    = datax_q;
    datay_d    = datay_q;
    addrw_d    = addrw_q;
    res_en_d   = 1'b0;
    res_tag_d  = res_tag_q;
    res_data_d = res_data_q;
    res_addr_d = res_addr_q;
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && cdb_live) begin
          if (tagx_q[i] == cdb_tag) begin
            tagx_d[i]  = '0;
            datax_d[i] = cdb_data;
          end
          if (tagy_q[i] == cdb_tag) begin
            tagy_d[i]  = '0;
            datay_d[i] = cdb_data;
          end
        end
      end
      if (issue_vld) begin
        valid_d[sel_idx] = 1'b0;
        res_en_d   = 1'b1;
        res_tag_d  = tagw_q[sel_idx];
        res_data_d = alu(op_q[sel_idx], datax_q[sel_idx], datay_q[sel_idx]);
        res_addr_d = addrw_q[sel_idx];
      end
      // The free slot is invalid in registered state, so it never collides with the issued one.
      if (alloc_vld) begin
        valid_d[free_idx] = 1'b1;
        op_d[free_idx]    = op_in;
        tagw_d[free_idx]  = tagw_in;
        addrw_d[free_idx] = addrw_in;
        tagx_d[free_idx]  = tagx_in;
        datax_d[free_idx] = datax_in;
        tagy_d[free_idx]  = tagy_in;
        datay_d[free_idx] = datay_in;
        if (cdb_live && (tagx_in == cdb_tag)) begin
          tagx_d[free_idx]  = '0;
          datax_d[free_idx] = cdb_data;
        end
        if (cdb_live && (tagy_in == cdb_tag)) begin
          tagy_d[free_idx]  = '0;
          datay_d[free_idx] = cdb_data;
        end
      end
      if (flush_act) begin
        valid_d    = '0;
        res_en_d   = 1'b0;
        res_tag_d  = res_tag_q;
        res_data_d = res_data_q;
        res_addr_d = res_addr_q;
      end
    end
  end

  // State registers; reset clears valid bits and the result port.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      res_en_q   <= 1'b0;
      res_tag_q  <= '0;
      res_data_q <= '0;
      res_addr_q <= '0;
    end else begin
      valid_q    <= valid_d;
      res_en_q   <= res_en_d;
      res_tag_q  <= res_tag_d;
      res_data_q <= res_data_d;
      res_addr_q <= res_addr_d;
    end
    op_q    <= op_d;
    tagx_q  <= tagx_d;
    tagy_q  <= tagy_d;
    tagw_q  <= tagw_d;
    datax_q <= datax_d;
    datay_q <= datay_d;
    addrw_q <= addrw_d;
  end

endmodule

// File: doc/alu_station.md
# alu_station

Reservation station for one ALU in the dual-issue out-of-order core. It sits directly downstream of the instruction allocator and accepts one ALU operation per cycle, tagged with operand and destination locks. Each entry watches the common data bus (CDB) until both operands are present. It then issues the oldest-index ready entry to an internal single-cycle ALU and broadcasts the result with its destination tag.

## Interface
Parameters:
- DEPTH, 4: number of entries (power of two, 2..8)
- TAG_W, 4: width of a register lock tag; tag value 0 means `UNLOCKED` (operand data valid)
- WORD_W, 32: data word width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low freezes all state
- en_in  in  1  allocate request from the allocator
- op_in  in  4  ALU operation (`sinst_t`)
- tagx_in, tagy_in  in  TAG_W  operand locks; 0 = data already present
- tagw_in  in  TAG_W  destination tag carried to the result
- datax_in, datay_in  in  WORD_W  operand data, valid when the matching tag is 0
- addrw_in  in  5  destination register address
- cdb_en  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB producer tag
- cdb_data  in  WORD_W  CDB value
- busy  out  1  all DEPTH entries occupied
- res_en  out  1  result valid, one-cycle pulse
- res_tag  out  TAG_W  tagw of the issued entry
- res_data  out  WORD_W  ALU result
- res_addr  out  5  addrw of the issued entry

## Operation
- Entry state: valid, op, tagx, tagy, datax, datay, tagw, addrw.
- **Allocation.** When rdy && en_in && !busy, write the lowest-index invalid entry.
  - If en_in is asserted while busy, the request is dropped. The allocator must not do this.
- **Capture bypass.** If cdb_en is high in the allocation cycle and cdb_tag == tagx_in (nonzero), the entry stores datax = cdb_data and tagx = 0. The same rule applies to y.
- **Wakeup.** Every rdy cycle, for each valid entry with tagx == cdb_tag != 0 and cdb_en high, set datax = cdb_data and tagx = 0. The same rule applies to y. Both operands may wake in the same cycle.
- **Ready.** An entry is ready when valid && tagx == 0 && tagy == 0, evaluated on registered state only.
- **Select.** The lowest-index ready entry issues. At most one issue per cycle.
- **Issue.** Compute the result. Register res_en=1, res_tag, res_data, res_addr. Clear the entry's valid bit at the same edge. If nothing is ready, res_en=0 and the other res_* outputs hold their values.
- **ALU ops:**
  - 0 ADD: x+y
  - 1 SUB: x−y
  - 2 SLL: x<<y[4:0]
  - 3 SLT: signed compare, result 1/0
  - 4 SLTU: unsigned compare, result 1/0
  - 5 XOR
  - 6 SRL: x>>y[4:0], logical
  - 7 SRA: arithmetic right shift by y[4:0]
  - 8 OR
  - 9 AND
  - 10 PASSY: y
  - 11–15: result 0
- All arithmetic is modulo 2^WORD_W. Overflow is ignored.
- **Freed slot.** A slot freed by issue is reusable from the next cycle. busy is computed from registered valid bits.
- **Reset.** Clears all valid bits. Outputs after reset: res_en=0, res_tag=0, res_data=0, res_addr=0, busy=0.

## Timing
- An entry allocated at edge N with both operands present produces res_en=1 after edge N+1. This is the minimum latency of 1 cycle.
- An entry woken by the CDB at edge N becomes ready after N and issues at edge N+1 at the earliest.
- When full and an entry issues at edge N, busy falls after N. An en_in arriving in the cycle before N is still dropped.
- While rdy is low, entries, tags, and res_* are frozen, except that res_en is forced to 0. en_in and cdb_en are ignored.
- rst has priority over rdy. Reset asserted mid-operation discards all pending entries. No result is emitted for them.

## Configuration
- ALU_STATION_FLUSH_EN
  - **Defined:** adds an input port `flush` (1 bit). When flush && rdy is high, all valid bits are cleared at the next edge and res_en is 0 after that edge. Any allocation or issue in that cycle is discarded. flush takes priority over en_in.
  - **Undefined:** the port is absent and the behaviour is as above.

## Test plan
- **Direct issue.** Reset, then allocate op=0 with x=5, y=7, tags 0, tagw=3, addrw=10. Required: the next cycle shows res_en=1, res_data=12, res_tag=3, res_addr=10. busy stays 0.
- **Wakeup.** Allocate op=1 with tagx=2, y=4, then hold 3 cycles with no result. Broadcast CDB tag 2 with data 9. Required: res_en the cycle after the broadcast, res_data=5.
- **Capture bypass.** Allocate op=7 with tagx=5, y=1 in the same cycle as CDB tag 5 with data 0x80000000. Required: next cycle res_data=0xC0000000.
- **Full.** With DEPTH=4, allocate 4 entries all waiting on tag 6. Required: busy=1. A fifth en_in is dropped. Broadcast tag 6. Required: entries issue in index order 0,1,2,3 on consecutive cycles, and busy falls after the first issue.
- **rdy stall and reset.** Drop rdy while two entries are pending. Required: res_en=0 and state is held. Raise rdy: the entries drain. Assert rst with entries pending: no res_en, busy=0, res_data=0.
- **Flush, macro defined.** Pulse flush with 3 pending entries. Required: busy=0 and no result is emitted for them. A later allocation issues normally.
